fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Dual-issue fetch stage directly upstream of the 2-read-port instruction ROM (4096 x 32b).
//   - Owns the PC and drives two ROM word addresses per cycle: PC and PC+4.
//   - ROM read data is combinational and returns in the same cycle; each returned word is
//     tagged with its PC and pushed into a circular instruction queue.
//   - Presents up to two in-order {pc, instr} entries to decode; flushes on redirect.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset.
//   DEPTH     8              Queue entries. Power of two, >= 4.
// PORTS
//   clk            in   1   Clock; rising edge.
//   rst_n          in   1   Asynchronous, active-low reset.
//   imem_a1_o      out  32  ROM address port 1 = pc.
//   imem_a2_o      out  32  ROM address port 2 = pc+4 (mod 2^32).
//   imem_rd1_i     in   32  ROM word at imem_a1_o, same cycle.
//   imem_rd2_i     in   32  ROM word at imem_a2_o, same cycle.
//   redirect_i     in   1   Branch/jump redirect from execute.
//   redirect_pc_i  in   32  Redirect target.
//   dec_valid_o    out  2   [0]: slot 0 valid; [1]: slot 1 valid (count >= 2).
//   dec_pc0_o      out  32  PC of the oldest queued entry.
//   dec_instr0_o   out  32  Instruction of the oldest queued entry.
//   dec_pc1_o      out  32  PC of the second-oldest entry.
//   dec_instr1_o   out  32  Instruction of the second-oldest entry.
//   dec_take_i     in   2   Entries decode consumes this cycle (0, 1 or 2).
// BEHAVIOUR
//   - Reset (async assert, sync deassert in the system): pc=RESET_PC, head=tail=count=0,
//     dec_valid_o=2'b00. The address outputs then show RESET_PC and RESET_PC+4.
//   - enq = !redirect_i && (count <= DEPTH-2).
//     - Uses the registered count only; there is no combinational path from dec_take_i to enq.
//     - When enq: write {pc, imem_rd1_i} at tail and {pc+4, imem_rd2_i} at tail+1;
//       tail += 2; pc += 8 (wraps mod 2^32).
//     - When !enq and !redirect_i: pc holds.
//   - Dequeue:
//     - take = min(dec_take_i, count); head += take. A value of 3 is treated as 2.
//     - dec_take_i > count is a protocol violation: the RTL clamps it, and an SVA assertion flags it.
//   - count_next = count + 2*enq - take. count is never below 0 or above DEPTH.
//   - Outputs are purely registered-state driven (zero-latency view of the queue head):
//     - dec_valid_o[0] = (count >= 1); dec_valid_o[1] = (count >= 2).
//     - Slot 0 = entry at head; slot 1 = entry at head+1.
//     - Data on invalid slots is don't-care.
//   - Fetch-to-decode latency: 1 cycle. A word addressed in cycle N is visible to decode in N+1.
//   - redirect_i has priority over everything:
//     - next cycle: pc=redirect_pc_i, head=tail=count=0;
//     - same-cycle enq and take are discarded.
//     - redirect_pc_i[1:0] is ignored (forced to 00).
//   - Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are decided by count, not by pointer compare.
//   - Throughput: with dec_take_i=2 every cycle, steady state is 2 instr/cycle.
//   - ROM index is address[13:2], so the PC aliases modulo 16 KiB. Aliasing is not flagged.
// STRUCTURE
//   - fetch_pkg (shared):
//     - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t;
//     - localparam ILEN=32, FETCH_WIDTH=2.
//   - Sub-module fetch_queue:
//     - 2-write/2-read circular buffer of fetch_entry_t, parameter DEPTH.
//     - Ports: wr_en, wr_data[2], rd_cnt, flush, count, rd_data[2].
//   - fetch_unit keeps the PC register, the enq decision and the redirect logic.
// TESTING
//   1. Reset, RESET_PC=0, ROM[i]=i:
//      - during reset, a1=0, a2=4, dec_valid=00;
//      - after release, cycle 1 gives dec_valid=11, pc0=0/instr0=0, pc1=4/instr1=1.
//   2. Stream with dec_take=2 held for 20 cycles:
//      - pc0 advances 0,8,16,... with no bubbles;
//      - count stays at 2.
//   3. Backpressure with dec_take=0:
//      - count goes 2,4,6,8, then enq stops;
//      - a1 holds at 32, i.e. 4 enqueues x 8 = 32 (first address not queued);
//      - then dec_take=1 for one cycle → count=7, no enq that cycle;
//      - next cycle count=7 → still no enq (7 > DEPTH-2).
//   4. Redirect to 0x100 while count=6 and dec_take=2:
//      - next cycle count=0, dec_valid=00, a1=0x100;
//      - following cycle pc0=0x100, pc1=0x104.
//   5. Wrap:
//      - run 3xDEPTH enqueue/dequeue pairs with alternating dec_take=1/2;
//      - scoreboard confirms in-order PCs across pointer wrap;
//      - also check PC wrap from 0xFFFF_FFF8 to 0.
//   6. Reset mid-operation:
//      - assert rst_n=0 asynchronously mid-cycle with count=5;
//      - outputs go immediately to dec_valid=00, a1=RESET_PC;
//      - no stale entries appear after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: the queued {pc, instr}
// entry and a helper that folds the illegal take encoding onto the max.
package fetch_pkg;

  localparam int ILEN        = 32;
  localparam int FETCH_WIDTH = 2;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Decode can take at most FETCH_WIDTH entries; an encoding of 3 means 2.
  function automatic logic [1:0] sat_take(input logic [1:0] t);
    return (t == 2'd3) ? 2'd2 : t;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-write / two-read circular buffer of fetch entries. Occupancy is
// tracked by an explicit counter; pointers simply wrap at DEPTH.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  fetch_entry_t [FETCH_WIDTH-1:0]     wr_data,
  input  logic [1:0]                         rd_cnt,
  input  logic                               flush,
  output logic [CW-1:0]                      count,
  output fetch_entry_t [FETCH_WIDTH-1:0]     rd_data
);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  fetch_entry_t  mem [DEPTH];

  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);

  // Pointer and occupancy update; a flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= tail + PW'(2);
      head  <= head + PW'(rd_cnt);
      count <= count + (wr_en ? CW'(2) : CW'(0)) - CW'(rd_cnt);
    end
  end

  // Entry storage; contents of empty slots are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem[tail]    <= wr_data[0];
      mem[tail_p1] <= wr_data[1];
    end
  end

  assign rd_data[0] = mem[head];
  assign rd_data[1] = mem[head_p1];

  // Occupancy must never exceed the storage.
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch stage: owns the PC, addresses two ROM words per cycle,
// queues them with their PCs and presents the two oldest entries to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_a1_o,
  output logic [31:0] imem_a2_o,
  input  logic [31:0] imem_rd1_i,
  input  logic [31:0] imem_rd2_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [1:0]  dec_valid_o,
  output logic [31:0] dec_pc0_o,
  output logic [31:0] dec_instr0_o,
  output logic [31:0] dec_pc1_o,
  output logic [31:0] dec_instr1_o,
  input  logic [1:0]  dec_take_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]                      pc;
  logic [CW-1:0]                    count;
  logic                             enq;
  logic [1:0]                       take_sat;
  logic [1:0]                       take;
  fetch_entry_t [FETCH_WIDTH-1:0]   wr_data;
  fetch_entry_t [FETCH_WIDTH-1:0]   rd_data;

  assign imem_a1_o = pc;
  assign imem_a2_o = pc + 32'd4;

  // Enqueue only from the registered count so decode's take never feeds fetch.
  assign enq = !redirect_i && (count <= CW'(DEPTH - 2));

  assign wr_data[0] = '{pc: pc,        instr: imem_rd1_i};
  assign wr_data[1] = '{pc: imem_a2_o, instr: imem_rd2_i};

  // Clamp the requested take to what is queued; a redirect discards it.
  always_comb begin
    take_sat = sat_take(dec_take_i);
    take     = take_sat;
    if (CW'(take_sat) > count) take = count[1:0];
    if (redirect_i) take = 2'd0;
  end

  // PC register: redirect wins, otherwise advance by a fetch pair on enqueue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_i) begin
      pc <= redirect_pc_i & ~32'd3;
    end else if (enq) begin
      pc <= pc + 32'd8;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (enq),
    .wr_data (wr_data),
    .rd_cnt  (take),
    .flush   (redirect_i),
    .count   (count),
    .rd_data (rd_data)
  );

  assign dec_valid_o  = {count >= CW'(2), count >= CW'(1)};
  assign dec_pc0_o    = rd_data[0].pc;
  assign dec_instr0_o = rd_data[0].instr;
  assign dec_pc1_o    = rd_data[1].pc;
  assign dec_instr1_o = rd_data[1].instr;

  // Decode must not ask for more entries than are presented.
  a_take_legal: assert property (@(posedge clk) disable iff (!rst_n)
    !redirect_i |-> (CW'(take_sat) <= count));

endmodule
